// File: rtl/fractal_sync_leaf.sv
// Leaf node of the fractal barrier tree: takes one barrier request from a core,
// pulses it up the tree, waits for the wake/error and returns a completion with status.
module fractal_sync_leaf #(
  parameter int unsigned AGGREGATE_WIDTH = 1,
  parameter int unsigned ID_WIDTH        = 1,
  parameter int unsigned TIMEOUT_CYCLES  = 1024
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       start_valid_i,
  output logic                       start_ready_o,
  input  logic [AGGREGATE_WIDTH-1:0] start_aggr_i,
  input  logic [ID_WIDTH-1:0]        start_id_i,
  output logic                       req_sync_o,
  output logic [AGGREGATE_WIDTH-1:0] req_aggr_o,
  output logic [ID_WIDTH-1:0]        req_id_o,
  input  logic                       rsp_wake_i,
  input  logic [AGGREGATE_WIDTH-1:0] rsp_aggr_i,
  input  logic [ID_WIDTH-1:0]        rsp_id_i,
  input  logic                       rsp_error_i,
  output logic                       done_valid_o,
  input  logic                       done_ready_i,
  output logic [1:0]                 done_status_o,
  output logic [15:0]                done_cycles_o,
  output logic                       spurious_o
);

  typedef enum logic [1:0] {IDLE, SEND, WAIT, DONE} state_e;

  localparam logic [1:0] ST_OK       = 2'd0;
  localparam logic [1:0] ST_TREE_ERR = 2'd1;
  localparam logic [1:0] ST_MISMATCH = 2'd2;
  localparam logic [1:0] ST_TIMEOUT  = 2'd3;

  // Counter value on the last permitted WAIT cycle; unused when the timeout is off.
  localparam logic [31:0] TO_LAST = (TIMEOUT_CYCLES == 0) ? 32'd0 : 32'(TIMEOUT_CYCLES - 1);
  localparam logic        TO_EN   = (TIMEOUT_CYCLES != 0);

  state_e                     state_q;
  logic [AGGREGATE_WIDTH-1:0] aggr_q;
  logic [ID_WIDTH-1:0]        id_q;
  logic [15:0]                cnt_q;
  logic [15:0]                cnt_inc;
  logic                       wake_match;
  logic                       timeout_hit;

  assign cnt_inc     = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
  assign wake_match  = (rsp_id_i == id_q) && (rsp_aggr_i == aggr_q);
  assign timeout_hit = TO_EN && ({16'd0, cnt_q} == TO_LAST);

  // Handshake outputs are pure state decodes, so no input reaches them combinationally.
  assign start_ready_o = (state_q == IDLE);
  assign done_valid_o  = (state_q == DONE);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      aggr_q        <= '0;
      id_q          <= '0;
      cnt_q         <= '0;
      req_sync_o    <= 1'b0;
      req_aggr_o    <= '0;
      req_id_o      <= '0;
      done_status_o <= ST_OK;
      done_cycles_o <= '0;
      spurious_o    <= 1'b0;
    end else begin
      if ((rsp_wake_i || rsp_error_i) && state_q != WAIT) spurious_o <= 1'b1;
      case (state_q)
        IDLE: begin
          if (start_valid_i) begin
            aggr_q     <= start_aggr_i;
            id_q       <= start_id_i;
            req_sync_o <= 1'b1;
            req_aggr_o <= start_aggr_i;
            req_id_o   <= start_id_i;
            state_q    <= SEND;
          end
        end
        SEND: begin
          req_sync_o <= 1'b0;
          req_aggr_o <= '0;
          req_id_o   <= '0;
          cnt_q      <= '0;
          state_q    <= WAIT;
        end
        WAIT: begin
          // Responses outrank the timeout; error outranks a wake in the same cycle.
          if (rsp_error_i || rsp_wake_i || timeout_hit) begin
            if (rsp_error_i)     done_status_o <= ST_TREE_ERR;
            else if (rsp_wake_i) done_status_o <= wake_match ? ST_OK : ST_MISMATCH;
            else                 done_status_o <= ST_TIMEOUT;
            done_cycles_o <= cnt_inc;
            state_q       <= DONE;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        DONE: begin
          if (done_ready_i) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fractal_sync_leaf.sv
// Directed bench for fractal_sync_leaf: table of barrier scenarios plus hand-written
// sequences for backpressure, mid-barrier reset, back-to-back and disabled timeout.
module tb_fractal_sync_leaf;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_valid = 1'b0, start_ready;
  logic [1:0]  start_aggr = '0, start_id = '0;
  logic        req_sync;
  logic [1:0]  req_aggr, req_id;
  logic        rsp_wake = 1'b0, rsp_error = 1'b0;
  logic [1:0]  rsp_aggr = '0, rsp_id = '0;
  logic        done_valid, done_ready = 1'b0;
  logic [1:0]  done_status;
  logic [15:0] done_cycles;
  logic        spurious;

  // second instance with the timeout disabled
  logic        z_start_valid = 1'b0, z_start_ready;
  logic        z_req_sync;
  logic [1:0]  z_req_aggr, z_req_id;
  logic        z_rsp_wake = 1'b0;
  logic        z_done_valid, z_done_ready = 1'b0;
  logic [1:0]  z_done_status;
  logic [15:0] z_done_cycles;
  logic        z_spurious;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fractal_sync_leaf #(.AGGREGATE_WIDTH(2), .ID_WIDTH(2), .TIMEOUT_CYCLES(8)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .start_valid_i(start_valid), .start_ready_o(start_ready),
    .start_aggr_i(start_aggr), .start_id_i(start_id),
    .req_sync_o(req_sync), .req_aggr_o(req_aggr), .req_id_o(req_id),
    .rsp_wake_i(rsp_wake), .rsp_aggr_i(rsp_aggr), .rsp_id_i(rsp_id), .rsp_error_i(rsp_error),
    .done_valid_o(done_valid), .done_ready_i(done_ready),
    .done_status_o(done_status), .done_cycles_o(done_cycles), .spurious_o(spurious)
  );

  fractal_sync_leaf #(.AGGREGATE_WIDTH(2), .ID_WIDTH(2), .TIMEOUT_CYCLES(0)) dut_z (
    .clk_i(clk), .rst_ni(rst_n),
    .start_valid_i(z_start_valid), .start_ready_o(z_start_ready),
    .start_aggr_i(2'd3), .start_id_i(2'd2),
    .req_sync_o(z_req_sync), .req_aggr_o(z_req_aggr), .req_id_o(z_req_id),
    .rsp_wake_i(z_rsp_wake), .rsp_aggr_i(2'd3), .rsp_id_i(2'd2), .rsp_error_i(1'b0),
    .done_valid_o(z_done_valid), .done_ready_i(z_done_ready),
    .done_status_o(z_done_status), .done_cycles_o(z_done_cycles), .spurious_o(z_spurious)
  );

  typedef struct {
    logic [1:0]  id;
    logic [1:0]  aggr;
    int          d;      // WAIT cycle (counter value) on which the response is applied
    logic        wake;
    logic [1:0]  wid;
    logic [1:0]  waggr;
    logic        err;
    logic [1:0]  exp_st;
    logic [15:0] exp_cyc;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_barrier(input logic [1:0] id, input logic [1:0] aggr);
    chk("start_ready_idle", start_ready, 1);
    start_valid = 1'b1; start_id = id; start_aggr = aggr;
    tick();
    start_valid = 1'b0;
    chk("req_sync_pulse", req_sync, 1);
    chk("req_id", req_id, id);
    chk("req_aggr", req_aggr, aggr);
    tick();
    chk("req_sync_end", req_sync, 0);
    chk("req_id_zero", {req_aggr, req_id}, 0);
  endtask

  task automatic handshake();
    done_ready = 1'b1;
    tick();
    done_ready = 1'b0;
    chk("done_valid_drop", done_valid, 0);
    chk("start_ready_back", start_ready, 1);
  endtask

  initial begin
    int accepts, pulses, dones, last_acc, bad_gap;
    logic wake_pending;

    tbl[0] = '{2'd1, 2'd1, 3, 1'b1, 2'd1, 2'd1, 1'b0, 2'd0, 16'd4};
    tbl[1] = '{2'd1, 2'd1, 0, 1'b1, 2'd0, 2'd1, 1'b0, 2'd2, 16'd1};
    tbl[2] = '{2'd2, 2'd3, 2, 1'b1, 2'd2, 2'd1, 1'b0, 2'd2, 16'd3};
    tbl[3] = '{2'd1, 2'd1, 1, 1'b1, 2'd1, 2'd1, 1'b1, 2'd1, 16'd2};
    tbl[4] = '{2'd3, 2'd2, 4, 1'b0, 2'd0, 2'd0, 1'b1, 2'd1, 16'd5};
    tbl[5] = '{2'd0, 2'd0, 6, 1'b1, 2'd0, 2'd0, 1'b0, 2'd0, 16'd7};
    tbl[6] = '{2'd2, 2'd1, 0, 1'b0, 2'd0, 2'd0, 1'b0, 2'd3, 16'd8};
    tbl[7] = '{2'd3, 2'd3, 7, 1'b1, 2'd3, 2'd3, 1'b0, 2'd0, 16'd8};
    tbl[8] = '{2'd1, 2'd2, 7, 1'b0, 2'd0, 2'd0, 1'b1, 2'd1, 16'd8};

    // reset state
    #2;
    chk("rst_start_ready", start_ready, 1);
    chk("rst_req", {req_sync, req_aggr, req_id}, 0);
    chk("rst_done", {done_valid, done_status, done_cycles}, 0);
    chk("rst_spurious", spurious, 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 9; i++) begin
      start_barrier(tbl[i].id, tbl[i].aggr);
      if (!tbl[i].wake && !tbl[i].err) begin
        for (int k = 0; k < 50 && !done_valid; k++) tick();
      end else begin
        for (int k = 0; k < tbl[i].d; k++) tick();
        chk("no_early_done", done_valid, 0);
        rsp_wake = tbl[i].wake; rsp_id = tbl[i].wid; rsp_aggr = tbl[i].waggr;
        rsp_error = tbl[i].err;
        tick();
        rsp_wake = 1'b0; rsp_error = 1'b0;
      end
      chk($sformatf("v%0d_done_valid", i), done_valid, 1);
      chk($sformatf("v%0d_status", i), done_status, tbl[i].exp_st);
      chk($sformatf("v%0d_cycles", i), done_cycles, tbl[i].exp_cyc);
      handshake();
    end
    chk("no_spurious_yet", spurious, 0);

    // backpressure with ignored start and a stray wake during DONE
    start_barrier(2'd2, 2'd2);
    rsp_wake = 1'b1; rsp_id = 2'd2; rsp_aggr = 2'd2;
    tick();
    rsp_wake = 1'b0;
    start_valid = 1'b1; start_id = 2'd1; start_aggr = 2'd1;
    for (int i = 0; i < 10; i++) begin
      chk("bp_done_valid", done_valid, 1);
      chk("bp_status", done_status, 0);
      chk("bp_cycles", done_cycles, 1);
      chk("bp_start_ready", start_ready, 0);
      chk("bp_no_req", req_sync, 0);
      tick();
      rsp_wake = (i == 4); rsp_id = 2'd0;
    end
    rsp_wake = 1'b0;
    chk("bp_spurious", spurious, 1);
    chk("bp_status_kept", done_status, 0);
    start_valid = 1'b0;
    handshake();
    chk("spurious_sticky", spurious, 1);

    // reset while waiting, then a late wake
    start_barrier(2'd1, 2'd1);
    tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", start_ready, 1);
    chk("mid_rst_spurious", spurious, 0);
    chk("mid_rst_outs", {req_sync, done_valid, done_status, done_cycles}, 0);
    tick();
    rst_n = 1'b1;
    tick();
    rsp_wake = 1'b1; rsp_id = 2'd1; rsp_aggr = 2'd1;
    tick();
    rsp_wake = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("late_no_done", done_valid, 0);
      tick();
    end
    chk("late_spurious", spurious, 1);
    chk("late_ready", start_ready, 1);

    // back-to-back barriers with immediate wakes
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    accepts = 0; pulses = 0; dones = 0; last_acc = -4; bad_gap = 0;
    wake_pending = 1'b0;
    start_valid = 1'b1; start_id = 2'd3; start_aggr = 2'd1;
    rsp_id = 2'd3; rsp_aggr = 2'd1;
    done_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (start_ready) begin
        accepts++;
        if (i - last_acc != 4) bad_gap++;
        last_acc = i;
      end
      tick();
      rsp_wake = wake_pending;
      wake_pending = 1'b0;
      if (req_sync) begin pulses++; wake_pending = 1'b1; end
      if (done_valid) begin
        dones++;
        chk("b2b_status", done_status, 0);
        chk("b2b_cycles", done_cycles, 1);
      end
    end
    start_valid = 1'b0; done_ready = 1'b0; rsp_wake = 1'b0;
    chk("b2b_accepts", accepts, 10);
    chk("b2b_pulses", pulses, 10);
    chk("b2b_dones", dones, 10);
    chk("b2b_gap", bad_gap, 0);
    chk("b2b_spurious", spurious, 0);

    // timeout disabled: stays in WAIT past counter saturation
    z_start_valid = 1'b1;
    tick();
    z_start_valid = 1'b0;
    chk("z_req", {z_req_sync, z_req_id, z_req_aggr}, {1'b1, 2'd2, 2'd3});
    tick();
    for (int i = 0; i < 70000; i++) begin
      if (z_done_valid) break;
      tick();
    end
    chk("z_no_done", z_done_valid, 0);
    chk("z_busy", z_start_ready, 0);
    z_rsp_wake = 1'b1;
    tick();
    z_rsp_wake = 1'b0;
    chk("z_done_valid", z_done_valid, 1);
    chk("z_status", z_done_status, 0);
    chk("z_cycles_sat", z_done_cycles, 16'hFFFF);
    chk("z_spurious", z_spurious, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fractal_sync_leaf.md
FRACTAL_SYNC_LEAF -- requirements
Module: fractal_sync_leaf

Interface
REQ-001 SHALL have parameter AGGREGATE_WIDTH, default 1, the width of the aggregate (level mask) field.
REQ-002 SHALL have parameter ID_WIDTH, default 1, the width of the barrier id field.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1024, the WAIT-state cycle limit; 0 disables the timeout.
REQ-004 SHALL have ports (name  direction  width  meaning):
- clk_i  in  1  clock; single clock domain
- rst_ni  in  1  asynchronous active-low reset
- start_valid_i  in  1  core barrier request valid
- start_ready_o  out  1  leaf can accept a request
- start_aggr_i  in  AGGREGATE_WIDTH  requested aggregate
- start_id_i  in  ID_WIDTH  requested barrier id
- req_sync_o  out  1  one-cycle sync pulse to the tree
- req_aggr_o  out  AGGREGATE_WIDTH  aggregate sent with the pulse
- req_id_o  out  ID_WIDTH  id sent with the pulse
- rsp_wake_i  in  1  one-cycle wake pulse from the tree
- rsp_aggr_i  in  AGGREGATE_WIDTH  aggregate carried by the wake
- rsp_id_i  in  ID_WIDTH  id carried by the wake
- rsp_error_i  in  1  one-cycle tree error pulse
- done_valid_o  out  1  completion valid
- done_ready_i  in  1  core accepts the completion
- done_status_o  out  2  completion status: 0 OK, 1 TREE_ERR, 2 MISMATCH, 3 TIMEOUT
- done_cycles_o  out  16  cycles spent in WAIT, saturating at 0xFFFF
- spurious_o  out  1  sticky flag: a response arrived outside WAIT

Function
REQ-005 SHALL implement the FSM states IDLE, SEND, WAIT and DONE, with one barrier outstanding at a time.
REQ-006 SHALL drive start_ready_o=1 only in IDLE.
REQ-007 SHALL, on start_valid_i & start_ready_o, latch start_aggr_i and start_id_i, then enter SEND.
REQ-008 SHALL, in SEND, drive req_sync_o=1 for exactly one cycle with the latched aggr/id on req_aggr_o/req_id_o, clear the wait counter, then enter WAIT.
REQ-009 SHALL drive req_aggr_o/req_id_o to 0 whenever req_sync_o=0.
REQ-010 SHALL, in WAIT, increment the wait counter each cycle and saturate it at 0xFFFF.
REQ-011 SHALL resolve WAIT exits by priority, each entering DONE on the next cycle:
- rsp_error_i -> status 1
- rsp_wake_i with id and aggr both matching the latched values -> status 0
- rsp_wake_i with any mismatch -> status 2
- counter == TIMEOUT_CYCLES-1 with TIMEOUT_CYCLES != 0 -> status 3
REQ-012 SHALL register done_cycles_o as the counter value plus 1 when leaving WAIT, saturated, so a wake in the first WAIT cycle reports 1.
REQ-013 SHALL, in DONE, hold done_valid_o=1 and keep done_status_o/done_cycles_o stable until done_ready_i=1, then enter IDLE.
REQ-014 SHALL accept a new start no earlier than the cycle after the DONE handshake, giving a minimum start-to-start period of 4 cycles.
REQ-015 SHALL set spurious_o on any rsp_wake_i or rsp_error_i sampled in IDLE, SEND or DONE; such a response SHALL NOT change FSM state or status.
REQ-016 SHALL clear spurious_o only by reset.
REQ-017 SHALL, when rsp_wake_i and rsp_error_i are both high in WAIT, report status 1.
REQ-018 SHALL, when a response and the timeout coincide in WAIT, give the response priority.
REQ-019 SHALL ignore start_valid_i outside IDLE; no request is queued.
REQ-020 SHALL keep all outputs registered or decoded from state only, with no combinational path from rsp_*_i or done_ready_i to any output.

Reset
REQ-021 SHALL, on rst_ni=0, asynchronously force:
- FSM to IDLE
- start_ready_o=1
- req_sync_o=0, req_aggr_o=0, req_id_o=0
- done_valid_o=0, done_status_o=0, done_cycles_o=0
- spurious_o=0
- latched aggr/id and wait counter to 0
REQ-022 SHALL, when reset is asserted mid-barrier (SEND/WAIT/DONE), abandon the barrier with no completion; a wake arriving after reset release is flagged spurious.

Verification
REQ-023 Basic: start id=1 aggr=1 at cycle 0 -> req_sync_o pulses at cycle 1 with id=1 aggr=1; wake id=1 aggr=1 at cycle 5 -> done_valid_o=1 status=0 cycles=4 at cycle 6.
REQ-024 Mismatch/error: wake id=0 while waiting on id=1 -> status 2; wake and rsp_error_i together -> status 1.
REQ-025 Timeout: TIMEOUT_CYCLES=8, no response -> done status=3, cycles=8; TIMEOUT_CYCLES=0 with 70000 idle cycles -> remains in WAIT.
REQ-026 Backpressure: done_ready_i=0 for 10 cycles -> done outputs stable, start_ready_o=0; a wake during DONE -> spurious_o=1 and status unchanged.
REQ-027 Reset mid-WAIT, then a wake after release -> no done_valid_o, spurious_o=1, start_ready_o=1.
REQ-028 Back-to-back: done_ready_i held 1 and start_valid_i held 1 -> starts accepted every 4 cycles with immediate wakes, exactly one req_sync_o pulse per start.
